// File: rtl/xoodoo_sca_round_ctrl.sv
// Round sequencer for a 2-share, 3-cycle threshold-implemented Xoodoo round core.
// Holds the state shares, paces the core through P0/P1/P2 and stalls on missing randomness.
module xoodoo_sca_round_ctrl #(
    parameter int unsigned NROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [383:0] din_0,
    input  logic [383:0] din_1,
    output logic         busy,
    output logic         done,
    output logic [383:0] dout_0,
    output logic [383:0] dout_1,
    input  logic [383:0] rnd_data,
    input  logic         rnd_valid,
    output logic         rnd_ready,
    output logic [383:0] core_in_0,
    output logic [383:0] core_in_1,
    output logic [383:0] core_rdi,
    output logic         core_rdi0_en,
    output logic         core_rdi1_en,
    output logic [31:0]  core_rconst,
    input  logic [383:0] core_out_0,
    input  logic [383:0] core_out_1
);

    localparam int unsigned W    = 384;
    localparam int unsigned RCW  = 4;
    localparam int unsigned SW   = 3;

    localparam logic [SW-1:0] S_IDLE = 3'd0;
    localparam logic [SW-1:0] S_P0   = 3'd1;
    localparam logic [SW-1:0] S_P1   = 3'd2;
    localparam logic [SW-1:0] S_P2   = 3'd3;
    localparam logic [SW-1:0] S_FIN  = 3'd4;

    // Shorter permutations use the tail of the 12-entry constant table.
    localparam logic [RCW-1:0] RC_OFS  = RCW'(12 - NROUNDS);
    localparam logic [RCW-1:0] RC_LAST = RCW'(NROUNDS - 1);

    logic [SW-1:0]  state_q, state_d;
    logic [RCW-1:0] rc_q, rc_d;
    logic [W-1:0]   sh0_q, sh0_d;
    logic [W-1:0]   sh1_q, sh1_d;
    logic           done_q, done_d;
    logic           rdi0_en_c;
    logic           rdi1_en_c;
    logic [RCW-1:0] rc_idx;
    logic [31:0]    rc_val;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rc_q    <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            done_q  <= done_d;
        end
    end

    // Next-state and core-enable logic.
    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        done_d    = 1'b0;
        rdi0_en_c = 1'b0;
        rdi1_en_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh0_d   = din_0;
                    sh1_d   = din_1;
                    rc_d    = '0;
                    state_d = S_P0;
                end
            end
            S_P0: begin
                if (rnd_valid) begin
                    rdi0_en_c = 1'b1;
                    // Previous round's result lands while the core takes the old value.
                    if (rc_q != '0) begin
                        sh0_d = core_out_0;
                        sh1_d = core_out_1;
                    end
                    state_d = S_P1;
                end
            end
            S_P1: begin
                if (rnd_valid) begin
                    rdi1_en_c = 1'b1;
                    state_d   = S_P2;
                end
            end
            S_P2: begin
                if (rc_q == RC_LAST) begin
                    state_d = S_FIN;
                end else begin
                    rc_d    = rc_q + RCW'(1);
                    state_d = S_P0;
                end
            end
            S_FIN: begin
                sh0_d   = core_out_0;
                sh1_d   = core_out_1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Xoodoo round-constant table.
    assign rc_idx = RC_OFS + rc_q;

    always_comb begin
        rc_val = 32'h0;
        case (rc_idx)
            4'd0:    rc_val = 32'h0000_0058;
            4'd1:    rc_val = 32'h0000_0038;
            4'd2:    rc_val = 32'h0000_03C0;
            4'd3:    rc_val = 32'h0000_00D0;
            4'd4:    rc_val = 32'h0000_0120;
            4'd5:    rc_val = 32'h0000_0014;
            4'd6:    rc_val = 32'h0000_0060;
            4'd7:    rc_val = 32'h0000_002C;
            4'd8:    rc_val = 32'h0000_0380;
            4'd9:    rc_val = 32'h0000_00F0;
            4'd10:   rc_val = 32'h0000_01A0;
            4'd11:   rc_val = 32'h0000_0012;
            default: rc_val = 32'h0;
        endcase
    end

    assign core_rconst  = (state_q == S_P0 || state_q == S_P1 || state_q == S_P2) ? rc_val : 32'h0;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign dout_0       = sh0_q;
    assign dout_1       = sh1_q;
    assign core_in_0    = sh0_q;
    assign core_in_1    = sh1_q;
    assign core_rdi     = rnd_data;
    assign core_rdi0_en = rdi0_en_c;
    assign core_rdi1_en = rdi1_en_c;
    assign rnd_ready    = rdi0_en_c | rdi1_en_c;

endmodule

// File: tb/tb_xoodoo_sca_round_ctrl.sv
// Directed bench for xoodoo_sca_round_ctrl with a behavioural 2-share round core
// and an unmasked Xoodoo reference.
module tb_xoodoo_sca_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, start6, rnd_valid;
    logic [383:0] din_0, din_1, rnd_data;

    logic         busy, done, rnd_ready, core_rdi0_en, core_rdi1_en;
    logic [383:0] dout_0, dout_1, core_in_0, core_in_1, core_rdi, core_out_0, core_out_1;
    logic [31:0]  core_rconst;

    logic         busy6, done6, rnd_ready6, rdi0_en6, rdi1_en6;
    logic [383:0] dout6_0, dout6_1, core_in6_0, core_in6_1, core_rdi6, core_out6_0, core_out6_1;
    logic [31:0]  core_rconst6;

    int checks = 0;
    int errors = 0;

    xoodoo_sca_round_ctrl #(.NROUNDS(12)) u12 (
        .clk(clk), .rst(rst), .start(start), .din_0(din_0), .din_1(din_1),
        .busy(busy), .done(done), .dout_0(dout_0), .dout_1(dout_1),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .core_in_0(core_in_0), .core_in_1(core_in_1), .core_rdi(core_rdi),
        .core_rdi0_en(core_rdi0_en), .core_rdi1_en(core_rdi1_en), .core_rconst(core_rconst),
        .core_out_0(core_out_0), .core_out_1(core_out_1)
    );

    xoodoo_sca_round_ctrl #(.NROUNDS(6)) u6 (
        .clk(clk), .rst(rst), .start(start6), .din_0(din_0), .din_1(din_1),
        .busy(busy6), .done(done6), .dout_0(dout6_0), .dout_1(dout6_1),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready6),
        .core_in_0(core_in6_0), .core_in_1(core_in6_1), .core_rdi(core_rdi6),
        .core_rdi0_en(rdi0_en6), .core_rdi1_en(rdi1_en6), .core_rconst(core_rconst6),
        .core_out_0(core_out6_0), .core_out_1(core_out6_1)
    );

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] rc_tab(input int i);
        case (i)
            0: return 32'h058;  1: return 32'h038;  2: return 32'h3C0;  3: return 32'h0D0;
            4: return 32'h120;  5: return 32'h014;  6: return 32'h060;  7: return 32'h02C;
            8: return 32'h380;  9: return 32'h0F0; 10: return 32'h1A0; 11: return 32'h012;
            default: return 32'h0;
        endcase
    endfunction

    // One unmasked Xoodoo round; lane (x,y) lives at bits [(4y+x)*32 +: 32].
    function automatic logic [383:0] xround(input logic [383:0] s, input logic [31:0] rc);
        logic [31:0] a [3][4];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [31:0] t [4];
        logic [31:0] b0, b1, b2;
        logic [383:0] r;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] = s[(4*y+x)*32 +: 32];
        for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
        for (int x = 0; x < 4; x++) t[x] = a[1][(x+3)%4];
        for (int x = 0; x < 4; x++) begin
            a[1][x] = t[x];
            a[2][x] = rotl(a[2][x], 11);
        end
        a[0][0] = a[0][0] ^ rc;
        for (int x = 0; x < 4; x++) begin
            b0 = ~a[1][x] & a[2][x];
            b1 = ~a[2][x] & a[0][x];
            b2 = ~a[0][x] & a[1][x];
            a[0][x] = a[0][x] ^ b0;
            a[1][x] = a[1][x] ^ b1;
            a[2][x] = a[2][x] ^ b2;
        end
        for (int x = 0; x < 4; x++) t[x] = a[2][(x+2)%4];
        for (int x = 0; x < 4; x++) begin
            a[1][x] = rotl(a[1][x], 1);
            a[2][x] = rotl(t[x], 8);
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) r[(4*y+x)*32 +: 32] = a[y][x];
        return r;
    endfunction

    function automatic logic [383:0] golden(input logic [383:0] v, input int n);
        logic [383:0] g = v;
        for (int i = 0; i < n; i++) g = xround(g, rc_tab(12 - n + i));
        return g;
    endfunction

    function automatic logic [383:0] rand384();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural round core: randomness in phase 0, compute on the phase-1 edge, fresh re-sharing.
    logic [383:0] m12_q, m6_q;
    always @(posedge clk) begin
        if (!rst) begin
            core_out_0 <= '0; core_out_1 <= '0; m12_q <= '0;
        end else begin
            if (core_rdi0_en) m12_q <= core_rdi;
            if (core_rdi1_en) begin
                core_out_0 <= xround(core_in_0 ^ core_in_1, core_rconst) ^ m12_q ^ core_rdi;
                core_out_1 <= m12_q ^ core_rdi;
            end
        end
    end
    always @(posedge clk) begin
        if (!rst) begin
            core_out6_0 <= '0; core_out6_1 <= '0; m6_q <= '0;
        end else begin
            if (rdi0_en6) m6_q <= core_rdi6;
            if (rdi1_en6) begin
                core_out6_0 <= xround(core_in6_0 ^ core_in6_1, core_rconst6) ^ m6_q ^ core_rdi6;
                core_out6_1 <= m6_q ^ core_rdi6;
            end
        end
    end

    task automatic kick(input logic [383:0] d0, input logic [383:0] d1);
        din_0 = d0; din_1 = d1; start = 1'b1;
        rnd_valid = 1'b1; rnd_data = rand384();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: no stalls; 1: stall P1 of round 3 (5 cyc) and P0 of round 7 (2 cyc); 2: start pulse while busy.
    task automatic wait_done(input int mode, output int lat, output logic [383:0] res,
                             output bit proto_bad, output bit stall_bad);
        int cnt = 1;
        bit exp1 = 1'b0;
        proto_bad = 1'b0; stall_bad = 1'b0;
        while (cnt < 300) begin
            rnd_data  = rand384();
            rnd_valid = !(mode == 1 && ((cnt >= 11 && cnt <= 15) || cnt == 27 || cnt == 28));
            start     = (mode == 2 && cnt == 10);
            if (mode == 2 && cnt == 10) begin din_0 = rand384(); din_1 = rand384(); end
            #1;
            if (rnd_ready !== (core_rdi0_en | core_rdi1_en)) proto_bad = 1'b1;
            if (core_rdi0_en && core_rdi1_en) proto_bad = 1'b1;
            if (core_rdi1_en && !exp1) proto_bad = 1'b1;
            if (core_rdi0_en) exp1 = 1'b1;
            if (core_rdi1_en) exp1 = 1'b0;
            if (!rnd_valid && (core_rdi0_en || core_rdi1_en)) stall_bad = 1'b1;
            if (done === 1'b1) break;
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        lat = cnt;
        res = dout_0 ^ dout_1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start6 = 1'b0; rnd_valid = 1'b0;
        din_0 = '0; din_1 = '0; rnd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (dout_0 !== '0 || dout_1 !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout_0 | dout_1); end
        checks++; if ({rnd_ready, core_rdi0_en, core_rdi1_en} !== 3'b000) begin errors++; $display("FAIL reset_en got %b exp 000", {rnd_ready, core_rdi0_en, core_rdi1_en}); end
        checks++; if (core_rconst !== 32'h0) begin errors++; $display("FAIL reset_rconst got %h exp 0", core_rconst); end
        checks++; if (busy6 !== 1'b0 || done6 !== 1'b0) begin errors++; $display("FAIL reset_u6 got %b%b exp 00", busy6, done6); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_runs();
        logic [383:0] d0, d1, res;
        int lat; bit pb, sb;
        for (int i = 0; i < 100; i++) begin
            d0 = rand384(); d1 = rand384();
            kick(d0, d1);
            wait_done(0, lat, res, pb, sb);
            checks++; if (lat != 38) begin errors++; $display("FAIL full_latency run %0d got %0d exp 38", i, lat); end
            checks++; if (res !== golden(d0 ^ d1, 12)) begin errors++; $display("FAIL full_result run %0d got %h exp %h", i, res, golden(d0 ^ d1, 12)); end
            checks++; if (pb) begin errors++; $display("FAIL full_protocol run %0d got violation exp none", i); end
        end
    endtask

    task automatic test_stall();
        logic [383:0] d0, d1, ra, rb;
        int lat; bit pb, sb;
        d0 = rand384(); d1 = rand384();
        kick(d0, d1);
        wait_done(0, lat, ra, pb, sb);
        kick(d0, d1);
        wait_done(1, lat, rb, pb, sb);
        checks++; if (lat != 45) begin errors++; $display("FAIL stall_latency got %0d exp 45", lat); end
        checks++; if (rb !== golden(d0 ^ d1, 12)) begin errors++; $display("FAIL stall_result got %h exp %h", rb, golden(d0 ^ d1, 12)); end
        checks++; if (rb !== ra) begin errors++; $display("FAIL stall_vs_nostall got %h exp %h", rb, ra); end
        checks++; if (sb) begin errors++; $display("FAIL stall_enables got enable-in-stall exp none"); end
        checks++; if (pb) begin errors++; $display("FAIL stall_protocol got violation exp none"); end
    endtask

    task automatic test_nrounds6();
        logic [31:0] exp6 [6] = '{32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};
        logic [31:0] seq [6];
        logic [383:0] d0, d1;
        int cnt = 1;
        int n = 0;
        bit pb = 1'b0;
        d0 = rand384(); d1 = rand384();
        din_0 = d0; din_1 = d1; start6 = 1'b1; rnd_valid = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        while (cnt < 200) begin
            rnd_data = rand384();
            #1;
            if (rnd_ready6 !== (rdi0_en6 | rdi1_en6) || (rdi0_en6 && rdi1_en6)) pb = 1'b1;
            if (rdi1_en6 && n < 6) begin seq[n] = core_rconst6; n++; end
            if (done6 === 1'b1) break;
            @(posedge clk); #1;
            cnt++;
        end
        checks++; if (n != 6) begin errors++; $display("FAIL r6_p1_count got %0d exp 6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (i < n && seq[i] !== exp6[i]) begin errors++; $display("FAIL r6_rconst[%0d] got %h exp %h", i, seq[i], exp6[i]); end
        end
        checks++; if (cnt != 20) begin errors++; $display("FAIL r6_latency got %0d exp 20", cnt); end
        checks++; if ((dout6_0 ^ dout6_1) !== golden(d0 ^ d1, 6)) begin errors++; $display("FAIL r6_result got %h exp %h", dout6_0 ^ dout6_1, golden(d0 ^ d1, 6)); end
        checks++; if (core_rconst6 !== 32'h0) begin errors++; $display("FAIL r6_rconst_idle got %h exp 0", core_rconst6); end
        checks++; if (pb) begin errors++; $display("FAIL r6_protocol got violation exp none"); end
    endtask

    task automatic test_protocol();
        logic [383:0] d0, d1, res, g;
        int lat; bit pb, sb;
        bit bad_busy = 1'b0, bad_done = 1'b0, bad_en = 1'b0, bad_hold = 1'b0;
        d0 = rand384(); d1 = rand384();
        g = golden(d0 ^ d1, 12);
        kick(d0, d1);
        wait_done(2, lat, res, pb, sb);
        checks++; if (lat != 38) begin errors++; $display("FAIL busy_start_latency got %0d exp 38", lat); end
        checks++; if (res !== g) begin errors++; $display("FAIL busy_start_result got %h exp %h", res, g); end
        checks++; if (pb) begin errors++; $display("FAIL busy_start_protocol got violation exp none"); end
        // Idle after completion: result must hold, done must not repeat.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rnd_data = rand384();
            if (done !== 1'b0) bad_done = 1'b1;
            if ((dout_0 ^ dout_1) !== g) bad_hold = 1'b1;
        end
        checks++; if (bad_done) begin errors++; $display("FAIL done_pulse got repeat exp single"); end
        checks++; if (bad_hold) begin errors++; $display("FAIL dout_hold got %h exp %h", dout_0 ^ dout_1, g); end
        bad_done = 1'b0;
        // Randomness never arrives: FSM must park in P0.
        din_0 = rand384(); din_1 = rand384(); rnd_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) bad_busy = 1'b1;
            if (done !== 1'b0) bad_done = 1'b1;
            if (core_rdi0_en || core_rdi1_en || rnd_ready) bad_en = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (bad_busy) begin errors++; $display("FAIL park_busy got 0 exp 1"); end
        checks++; if (bad_done) begin errors++; $display("FAIL park_done got 1 exp 0"); end
        checks++; if (bad_en) begin errors++; $display("FAIL park_enables got 1 exp 0"); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        logic [383:0] d0, d1, res;
        int lat; bit pb, sb;
        int cnt = 1;
        d0 = rand384(); d1 = rand384();
        kick(d0, d1);
        while (cnt < 17) begin
            rnd_valid = 1'b1; rnd_data = rand384();
            @(posedge clk); #1;
            cnt++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
        checks++; if (dout_0 !== '0 || dout_1 !== '0) begin errors++; $display("FAIL midrst_dout got %h exp 0", dout_0 | dout_1); end
        checks++; if ({rnd_ready, core_rdi0_en, core_rdi1_en} !== 3'b000) begin errors++; $display("FAIL midrst_en got %b exp 000", {rnd_ready, core_rdi0_en, core_rdi1_en}); end
        rst = 1'b1;
        @(posedge clk); #1;
        d0 = rand384(); d1 = rand384();
        kick(d0, d1);
        wait_done(0, lat, res, pb, sb);
        checks++; if (lat != 38) begin errors++; $display("FAIL midrst_rerun_latency got %0d exp 38", lat); end
        checks++; if (res !== golden(d0 ^ d1, 12)) begin errors++; $display("FAIL midrst_rerun_result got %h exp %h", res, golden(d0 ^ d1, 12)); end
    endtask

    task automatic test_back_to_back();
        logic [383:0] a0, a1, b0, b1, res;
        int lat; bit pb, sb;
        a0 = rand384(); a1 = rand384(); b0 = rand384(); b1 = rand384();
        kick(a0, a1);
        wait_done(0, lat, res, pb, sb);
        checks++; if (res !== golden(a0 ^ a1, 12)) begin errors++; $display("FAIL b2b_first got %h exp %h", res, golden(a0 ^ a1, 12)); end
        kick(b0, b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", busy); end
        checks++; if (dout_0 !== b0 || dout_1 !== b1) begin errors++; $display("FAIL b2b_capture got %h exp %h", dout_0, b0); end
        wait_done(0, lat, res, pb, sb);
        checks++; if (lat != 38) begin errors++; $display("FAIL b2b_latency got %0d exp 38", lat); end
        checks++; if (res !== golden(b0 ^ b1, 12)) begin errors++; $display("FAIL b2b_second got %h exp %h", res, golden(b0 ^ b1, 12)); end
    endtask

    initial begin
        test_reset();
        test_full_runs();
        test_stall();
        test_nrounds6();
        test_protocol();
        test_reset_midrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xoodoo_sca_round_ctrl.md
Name: xoodoo_sca_round_ctrl

Overview:
Sequencer for the first-order threshold-implemented Xoodoo round core (3-cycle, 2-share round datapath with a 384-bit fresh-randomness input).
- Holds the two 384-bit state shares and feeds them to the round core each round.
- Drives the core's randomness-load enables and round constant, and accepts randomness from the PRNG through a valid/ready handshake, stalling when it is not available.
- Sits between the Xoodyak permutation-call logic and one round-core instance; runs NROUNDS rounds per start.

Parameters:
NROUNDS, 12, rounds per permutation (1..12); uses the last NROUNDS Xoodoo constants.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
start  in  1  begin permutation; sampled only in IDLE
din_0  in  384  state share 0, captured on accepted start
din_1  in  384  state share 1, captured on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; dout valid
dout_0  out  384  state share 0 register
dout_1  out  384  state share 1 register
rnd_data  in  384  fresh randomness from PRNG
rnd_valid  in  1  rnd_data valid
rnd_ready  out  1  randomness consumed this cycle
core_in_0  out  384  share 0 to round core (state register 0)
core_in_1  out  384  share 1 to round core (state register 1)
core_rdi  out  384  randomness to round core (= rnd_data)
core_rdi0_en  out  1  round-core phase-0 load
core_rdi1_en  out  1  round-core phase-1 load/compute
core_rconst  out  32  round constant
core_out_0  in  384  round-core output share 0
core_out_1  in  384  round-core output share 1

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, round counter=0, both state registers=0, done=0. busy, rnd_ready and both enables are 0. Reset mid-run aborts immediately with no done pulse. The round core is reset by the same net, inverted at integration.
- FSM states: IDLE, P0, P1, P2, FIN.
- IDLE + start: state regs <= din; rc <= 0; go to P0. A start with busy=1 is ignored.
- P0, rnd_valid=1:
  - core_rdi0_en=1, rnd_ready=1.
  - If rc!=0, state regs <= core_out; the core samples the old D on the same edge.
  - Go to P1.
- P0, rnd_valid=0: hold; both enables 0.
- P1, rnd_valid=1: core_rdi1_en=1, rnd_ready=1, go to P2. If rnd_valid=0: hold, enables 0.
- P2: no enables, no randomness. If rc==NROUNDS-1, go to FIN; otherwise rc <= rc+1 and go to P0. P2 never stalls.
- FIN: state regs <= core_out, go to IDLE. done=1 for exactly the first IDLE cycle.
- Enable rules:
  - rnd_ready == core_rdi0_en | core_rdi1_en at all times.
  - core_rdi0_en and core_rdi1_en are never high together.
  - core_rdi1_en is only ever asserted in the cycle after a core_rdi0_en cycle, possibly with stall cycles in between.
- core_rconst:
  - Table RC[0..11] = 058,038,3C0,0D0,120,014,060,02C,380,0F0,1A0,012 (hex, zero-extended to 32 bits).
  - Output RC[12-NROUNDS+rc], valid whenever the FSM is in P1. Drive 0 outside P0..P2.
- Latency with no stalls: start accepted at cycle t; P0 of round k at t+1+3k; FIN at t+3*NROUNDS+1; done at t+3*NROUNDS+2.
  - NROUNDS=12: done at t+38.
  - Each stall cycle adds one cycle.
- dout_0/dout_1 hold the state registers continuously and are stable from the done cycle until the next accepted start.
- The state registers are written only on accepted start, P0-fire with rc!=0, and FIN. Shares are never combined inside this block.

Test Plan:
- Full run, NROUNDS=12, random din shares, random rnd_data every cycle, rnd_valid=1 -> done at t+38; dout_0^dout_1 equals the unmasked Xoodoo golden model of din_0^din_1. Repeat for 100 random inputs.
- Stall: rnd_valid=0 for 5 cycles during P1 of round 3 and 2 cycles during P0 of round 7 -> done at t+45, same result as the unstalled run; no enable asserted during stall cycles.
- NROUNDS=6 -> core_rconst sequence in P1 is 060,02C,380,0F0,1A0,012; done at t+20; result matches the 6-round golden model.
- Protocol: start pulsed while busy -> ignored, result unchanged. rnd_valid held 0 -> FSM parks in P0, busy=1, no done. Assertions check rnd_ready==rdi0_en|rdi1_en and that the two enables are mutually exclusive.
- Reset at cycle t+17 mid-run -> next cycle busy=0, done=0, dout=0, enables 0. A subsequent start completes correctly at t'+38.
- Back-to-back: start asserted in the done cycle -> accepted; second result correct; the first result is visible on dout for exactly that one cycle.
